md5_pad: RTL

MD5_PAD -- requirements
Module: md5_pad

---
 rtl/md5_pkg.sv | 16 +
 rtl/md5_pad.sv | 139 +++++++++++++
 2 files changed

// File: rtl/md5_pkg.sv
// Shared MD5 constants and the padder state encoding.
package md5_pkg;

  localparam int unsigned MD5_BLOCK_W  = 512;
  localparam int unsigned MD5_LEN_W    = 64;
  localparam logic [7:0]  MD5_PAD_BYTE = 8'h80;
  localparam int unsigned MD5_LEN_OFS  = 56;

  typedef enum logic [1:0] {
    PAD_FILL,
    PAD_EMIT,
    PAD_EXTRA,
    PAD_DONE_EMIT
  } pad_state_e;

endpackage

// File: rtl/md5_pad.sv
// MD5 message padder: packs a byte stream into 512-bit chunks, appends 0x80,
// zero fill and the little-endian 64-bit bit length.
module md5_pad (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  output logic         blk_last,
  input  logic         blk_ready
);
  import md5_pkg::*;

  pad_state_e                 state_q, state_d;
  logic [MD5_BLOCK_W-1:0]     chunk_q, chunk_d;
  logic [5:0]                 cnt_q, cnt_d;
  logic [MD5_LEN_W-1:0]       len_q, len_d;
  logic                       xtra_q, xtra_d;
  logic                       xpad_q, xpad_d;
  logic                       run_q;
  logic                       accept;
  logic                       has_byte;
  logic [6:0]                 fill_n;

  assign accept   = (state_q == PAD_FILL) && run_q && in_valid;
  assign has_byte = !in_empty;
  // bytes in the current chunk once this beat is written (0..64)
  assign fill_n   = {1'b0, cnt_q} + {6'd0, has_byte};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PAD_FILL;
      chunk_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      xtra_q  <= 1'b0;
      xpad_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      xtra_q  <= xtra_d;
      xpad_q  <= xpad_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    xtra_d  = xtra_q;
    xpad_d  = xpad_q;
    unique case (state_q)
      PAD_FILL: begin
        if (accept) begin
          if (has_byte) begin
            chunk_d[{cnt_q, 3'b000} +: 8] = in_data;
            len_d = len_q + 64'd8;
          end
          if (in_last) begin
            cnt_d = '0;
            if (fill_n == 7'd64) begin
              state_d = PAD_EMIT;
              xtra_d  = 1'b1;
              xpad_d  = 1'b1;
            end else begin
              chunk_d[{fill_n[5:0], 3'b000} +: 8] = MD5_PAD_BYTE;
              if (fill_n < 7'(MD5_LEN_OFS)) begin
                chunk_d[MD5_LEN_OFS*8 +: MD5_LEN_W] = len_d;
                state_d = PAD_DONE_EMIT;
              end else begin
                state_d = PAD_EMIT;
                xtra_d  = 1'b1;
                xpad_d  = 1'b0;
              end
            end
          end else if (has_byte) begin
            if (cnt_q == 6'd63) begin
              cnt_d   = '0;
              state_d = PAD_EMIT;
              xtra_d  = 1'b0;
              xpad_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
      end
      PAD_EMIT: begin
        if (blk_ready) begin
          // trailing chunk is built on the transfer edge so it is valid next cycle
          chunk_d = '0;
          if (xtra_q) begin
            chunk_d[MD5_LEN_OFS*8 +: MD5_LEN_W] = len_q;
            if (xpad_q) chunk_d[7:0] = MD5_PAD_BYTE;
            state_d = PAD_EXTRA;
            xtra_d  = 1'b0;
            xpad_d  = 1'b0;
          end else begin
            state_d = PAD_FILL;
          end
        end
      end
      PAD_EXTRA, PAD_DONE_EMIT: begin
        if (blk_ready) begin
          chunk_d = '0;
          cnt_d   = '0;
          len_d   = '0;
          state_d = PAD_FILL;
        end
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    unique case (state_q)
      PAD_FILL:  in_ready = run_q;
      PAD_EMIT:  blk_valid = 1'b1;
      PAD_EXTRA, PAD_DONE_EMIT: begin
        blk_valid = 1'b1;
        blk_last  = 1'b1;
      end
    endcase
  end

  assign blk_data = chunk_q;

endmodule
